// File: rtl/multi_timer.sv
// multi_timer: N-channel programmable down-counter timer with one-shot or
// auto-reload mode, a sticky pending flag and an interrupt mask per channel.
// Registers are word-addressed as {channel, reg}; reads are combinational.
module multi_timer #(
    parameter int          N_CH       = 2,
    parameter int          WIDTH      = 32,
    parameter logic [31:0] PRESET_RST = 32'h0000_1111,
    parameter int          AW         = $clog2(N_CH) + 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    output logic [N_CH-1:0] irq_vec,
    output logic            IRQ
);

    localparam logic [WIDTH-1:0] RST_VAL = PRESET_RST[WIDTH-1:0];

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    logic [AW-1:0] ch_sel;
    logic [1:0]    reg_sel;

    logic             en_q    [N_CH];
    logic [1:0]       mode_q  [N_CH];
    logic             im_q    [N_CH];
    logic             pend_q  [N_CH];
    logic [WIDTH-1:0] preset_q[N_CH];
    logic [WIDTH-1:0] count_q [N_CH];

    logic [N_CH-1:0] wr_ctrl;
    logic [N_CH-1:0] wr_preset;
    logic [N_CH-1:0] w1c;
    logic [N_CH-1:0] tc_event;

    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];

    // Per-channel write decode and terminal-event detection; a register write
    // to CTRL or PRESET takes the cycle, so no count or event happens then.
    always_comb begin
        wr_ctrl   = '0;
        wr_preset = '0;
        w1c       = '0;
        tc_event  = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr_ctrl[i]   = we && (ch_sel == AW'(i)) && (reg_sel == REG_CTRL);
            wr_preset[i] = we && (ch_sel == AW'(i)) && (reg_sel == REG_PRESET);
            w1c[i]       = we && (ch_sel == AW'(i)) && (reg_sel == REG_STATUS) && din[0];
            tc_event[i]  = en_q[i] && (count_q[i] == '0) && !wr_ctrl[i] && !wr_preset[i];
        end
    end

    // Channel state: reset, register writes, then count / terminal handling.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (rst) begin
                en_q[i]     <= 1'b0;
                mode_q[i]   <= 2'b00;
                im_q[i]     <= 1'b0;
                pend_q[i]   <= 1'b0;
                preset_q[i] <= RST_VAL;
                count_q[i]  <= RST_VAL;
            end else begin
                if (wr_ctrl[i]) begin
                    en_q[i]   <= din[0];
                    mode_q[i] <= din[2:1];
                    im_q[i]   <= din[3];
                end else if (wr_preset[i]) begin
                    preset_q[i] <= din[WIDTH-1:0];
                    count_q[i]  <= din[WIDTH-1:0];
                    en_q[i]     <= 1'b1;
                end else if (en_q[i]) begin
                    if (count_q[i] != '0) begin
                        count_q[i] <= count_q[i] - WIDTH'(1);
                    end else if (mode_q[i] == 2'b01) begin
                        count_q[i] <= preset_q[i];
                    end else begin
                        en_q[i] <= 1'b0;
                    end
                end

                // A terminal event outranks a simultaneous W1C.
                if (tc_event[i]) begin
                    pend_q[i] <= 1'b1;
                end else if (w1c[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Read mux; out-of-range channels and unused bits read as zero.
    always_comb begin
        dout = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    REG_CTRL:   dout = {28'd0, im_q[i], mode_q[i], en_q[i]};
                    REG_PRESET: dout = 32'(preset_q[i]);
                    REG_COUNT:  dout = 32'(count_q[i]);
                    default:    dout = {31'd0, pend_q[i]};
                endcase
            end
        end
    end

    // Interrupt outputs: masked pending flags and their OR.
    always_comb begin
        irq_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            irq_vec[i] = pend_q[i] & im_q[i];
        end
        IRQ = |irq_vec;
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: default 2x32 instance plus a 3x8 instance.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  irq_vec;
    logic        irq;

    logic        we2;
    logic [3:0]  addr2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic [2:0]  irq_vec2;
    logic        irq2;

    int errors = 0;
    int checks = 0;
    logic [31:0] v;

    multi_timer dut (
        .clk(clk), .rst(rst), .we(we), .addr(addr), .din(din),
        .dout(dout), .irq_vec(irq_vec), .IRQ(irq)
    );

    multi_timer #(.N_CH(3), .WIDTH(8)) dut2 (
        .clk(clk), .rst(rst), .we(we2), .addr(addr2), .din(din2),
        .dout(dout2), .irq_vec(irq_vec2), .IRQ(irq2)
    );

    always #10 clk = ~clk;

    // Called at a negedge: the write lands on the next posedge, returns at the following negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic wr2(input logic [3:0] a, input logic [31:0] d);
        we2 = 1'b1; addr2 = a; din2 = d;
        @(negedge clk);
        we2 = 1'b0;
    endtask

    task automatic rd2(input logic [3:0] a, output logic [31:0] d);
        addr2 = a;
        #1;
        d = dout2;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h0; exp_v[1] = 32'h1111; exp_v[2] = 32'h1111; exp_v[3] = 32'h0;
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd(3'(c * 4 + r), v);
                checks++;
                if (v !== exp_v[r]) begin
                    errors++;
                    $display("FAIL reset_ch%0d_reg%0d got=%h exp=%h", c, r, v, exp_v[r]);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (irq !== 1'b0 || irq_vec !== 2'b00) begin
            errors++;
            $display("FAIL reset_irq got=%b/%b exp=0/00", irq, irq_vec);
        end
        rd2(4'd10, v);
        checks++;
        if (v !== 32'h11) begin
            errors++;
            $display("FAIL reset_w8_count got=%h exp=%h", v, 32'h11);
        end
    endtask

    task automatic test_oneshot();
        wr(3'd0, 32'h8);
        wr(3'd1, 32'd3);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd3 || irq !== 1'b0) begin
            errors++;
            $display("FAIL os_load got=%h irq=%b exp=3 irq=0", v, irq);
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rd(3'd2, v);
            checks++;
            if (v !== 32'(3 - k) || irq !== 1'b0) begin
                errors++;
                $display("FAIL os_count%0d got=%h irq=%b exp=%h irq=0", k, v, irq, 32'(3 - k));
            end
        end
        @(negedge clk);
        rd(3'd3, v);
        checks++;
        if (v !== 32'h1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL os_pend got=%h irq=%b exp=1 irq=1", v, irq);
        end
        rd(3'd0, v);
        checks++;
        if (v !== 32'h8) begin
            errors++;
            $display("FAIL os_ctrl_en_clr got=%h exp=%h", v, 32'h8);
        end
        @(negedge clk);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL os_count_hold got=%h exp=0", v);
        end
    endtask

    task automatic test_autoreload();
        wr(3'd4, 32'hA);
        wr(3'd5, 32'd2);
        @(negedge clk);
        @(negedge clk);
        rd(3'd6, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL ar_zero got=%h exp=0", v);
        end
        @(negedge clk);
        rd(3'd7, v);
        checks++;
        if (v !== 32'h1 || irq_vec[1] !== 1'b1) begin
            errors++;
            $display("FAIL ar_event1 got=%h irq1=%b exp=1 irq1=1", v, irq_vec[1]);
        end
        rd(3'd6, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL ar_reload got=%h exp=2", v);
        end
        wr(3'd7, 32'h1);
        rd(3'd7, v);
        checks++;
        if (v !== 32'h0 || irq_vec[1] !== 1'b0) begin
            errors++;
            $display("FAIL ar_w1c got=%h irq1=%b exp=0 irq1=0", v, irq_vec[1]);
        end
        @(negedge clk);
        wr(3'd7, 32'h1);
        rd(3'd7, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL ar_w1c_vs_event got=%h exp=1", v);
        end
        rd(3'd6, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL ar_reload2 got=%h exp=2", v);
        end
    endtask

    task automatic test_mask();
        wr(3'd4, 32'h0);
        wr(3'd7, 32'h1);
        wr(3'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_clear_all irq got=%b exp=0", irq);
        end
        wr(3'd0, 32'h0);
        wr(3'd1, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rd(3'd3, v);
        checks++;
        if (v !== 32'h1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL mask_pend_noirq got=%h irq=%b exp=1 irq=0", v, irq);
        end
        wr(3'd3, 32'h0);
        rd(3'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL mask_w0_noeffect got=%h exp=1", v);
        end
        wr(3'd0, 32'h8);
        checks++;
        if (irq !== 1'b1 || irq_vec !== 2'b01) begin
            errors++;
            $display("FAIL mask_unmask irq=%b vec=%b exp=1/01", irq, irq_vec);
        end
        wr(3'd3, 32'h1);
        checks++;
        if (irq !== 1'b0 || irq_vec !== 2'b00) begin
            errors++;
            $display("FAIL mask_w1c irq=%b vec=%b exp=0/00", irq, irq_vec);
        end
    endtask

    task automatic test_collision();
        wr(3'd0, 32'h2);
        wr(3'd1, 32'd2);
        @(negedge clk);
        @(negedge clk);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL col_zero got=%h exp=0", v);
        end
        wr(3'd1, 32'd5);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL col_count got=%h exp=5", v);
        end
        rd(3'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL col_nopend got=%h exp=0", v);
        end
        @(negedge clk);
        wr(3'd0, 32'h0);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL col_freeze got=%h exp=4", v);
        end
        @(negedge clk);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd4) begin
            errors++;
            $display("FAIL col_freeze_hold got=%h exp=4", v);
        end
        wr(3'd0, 32'h3);
        @(negedge clk);
        rd(3'd2, v);
        checks++;
        if (v !== 32'd3) begin
            errors++;
            $display("FAIL col_resume got=%h exp=3", v);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd(3'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL col_rst_ctrl got=%h exp=0", v);
        end
        rd(3'd1, v);
        checks++;
        if (v !== 32'h1111) begin
            errors++;
            $display("FAIL col_rst_preset got=%h exp=%h", v, 32'h1111);
        end
        rd(3'd2, v);
        checks++;
        if (v !== 32'h1111) begin
            errors++;
            $display("FAIL col_rst_count got=%h exp=%h", v, 32'h1111);
        end
        @(negedge clk);
        rd(3'd2, v);
        checks++;
        if (v !== 32'h1111 || irq !== 1'b0) begin
            errors++;
            $display("FAIL col_rst_hold got=%h irq=%b exp=1111 irq=0", v, irq);
        end
    endtask

    task automatic test_width();
        wr2(4'd1, 32'h1FF);
        rd2(4'd1, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++;
            $display("FAIL w8_preset_trunc got=%h exp=%h", v, 32'hFF);
        end
        rd2(4'd2, v);
        checks++;
        if (v !== 32'hFF) begin
            errors++;
            $display("FAIL w8_count_trunc got=%h exp=%h", v, 32'hFF);
        end
        wr2(4'd13, 32'd5);
        rd2(4'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL w8_ch3_read got=%h exp=0", v);
        end
        rd2(4'd5, v);
        checks++;
        if (v !== 32'h11) begin
            errors++;
            $display("FAIL w8_ch3_alias got=%h exp=%h", v, 32'h11);
        end
        @(negedge clk);
        wr2(4'd5, 32'd3);
        wr2(4'd9, 32'd5);
        rd2(4'd6, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL w8_ch1_count got=%h exp=2", v);
        end
        rd2(4'd10, v);
        checks++;
        if (v !== 32'd5) begin
            errors++;
            $display("FAIL w8_ch2_load got=%h exp=5", v);
        end
        repeat (3) @(negedge clk);
        rd2(4'd7, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL w8_ch1_pend got=%h exp=1", v);
        end
        rd2(4'd10, v);
        checks++;
        if (v !== 32'd2) begin
            errors++;
            $display("FAIL w8_ch2_count got=%h exp=2", v);
        end
        rd2(4'd11, v);
        checks++;
        if (v !== 32'h0 || irq2 !== 1'b0) begin
            errors++;
            $display("FAIL w8_ch2_pend got=%h irq=%b exp=0 irq=0", v, irq2);
        end
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0; addr = '0; din = '0;
        we2 = 1'b0; addr2 = '0; din2 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_mask();
        test_collision();
        test_width();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
